mr_chips_control: RTL and testbench
===================================

Name: mr_chips_control

Overview:
- Multi-cycle control sequencer for the mr_chips 16-bit core.
- Fetches instructions over a req/ready instruction-memory port and decodes them into R, I and J classes.
- Steps the shared register file, ALU and data-memory port through FETCH/DECODE/EXEC/MEM/WB, one instruction at a time.
- Owns the PC; the datapath (register file, ALU, memory data muxing) sits outside and follows its strobes.

Parameters:
PC_W, 12, PC and memory word-address width; word-addressed.
DATA_W, 8, datapath width; immediate is sign-extended to this width.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
imem_req  output  1  instruction fetch request
imem_addr  output  PC_W  fetch address (= pc)
imem_ready  input  1  fetch complete; imem_rdata valid this cycle
imem_rdata  input  16  fetched instruction
dmem_req  output  1  data memory request
dmem_we  output  1  1 = store, 0 = load; valid while dmem_req
dmem_ready  input  1  data access complete
alu_zero  input  1  ALU result == 0, from the datapath
alu_op  output  3  000 add, 001 sub, 010 and; R-type passes funct through
alu_b_sel  output  1  0 = register B, 1 = sign-extended immediate
imm_ext  output  DATA_W  sign-extended instr[11:6]
ra_addr  output  3  register read port A
rb_addr  output  3  register read port B
wb_addr  output  3  writeback register
wb_sel  output  2  00 ALU, 01 memory data, 10 pc+1 (low DATA_W bits)
reg_we  output  1  register write strobe, single cycle
pc  output  PC_W  current PC
retire  output  1  one-cycle pulse per completed instruction
halted  output  1  sticky; core stopped
illegal  output  1  sticky; halted on undefined opcode

Behaviour:
- Field layout:
  - Opcode = ir[15:12].
  - R-type (0000): funct ir[11:9], rs ir[8:6], rt ir[5:3], rd ir[2:0].
  - I-type (0001-0110): imm ir[11:6], rt ir[5:3], rd ir[2:0].
  - J-type (0111-1001): addr ir[11:0].
- Opcodes:
  - 0000 R: ra=rs, rb=rt, alu_op=funct, wb rd.
  - 0001 addi: ra=rt, B=imm, add, wb rd.
  - 0010 lw: addr = rt+imm; wb rd from memory.
  - 0011 sw: addr = rt+imm; data register = rd (rb=rd).
  - 0100 beq / 0101 bne: ra=rt, rb=rd, sub; taken if alu_zero==1 (beq) / 0 (bne).
  - 0110 andi: ra=rt, B=imm, and, wb rd.
  - 0111 j: pc=addr.
  - 1000 jal: r7 <= pc+1, pc=addr.
  - 1001 halt.
  - 1010-1111: illegal.
- States and transitions:
  - FETCH: imem_req=1 until imem_ready. ir latched on the ready cycle; zero-wait ready (same cycle as first req) accepted. Next: DECODE.
  - DECODE: 1 cycle; drives ra/rb/wb/imm_ext/alu_op. Next: EXEC, or HALT for halt/illegal.
  - EXEC: 1 cycle; ALU evaluates, alu_zero sampled at the end of the cycle.
    - Branch: pc <= taken ? pc+1+sext(imm) : pc+1; retire; next FETCH.
    - j: pc <= addr; retire; next FETCH.
    - lw/sw: next MEM. Others: next WB.
  - MEM: dmem_req=1, dmem_we=(sw), held stable until dmem_ready.
    - sw: on ready, pc+1, retire, next FETCH.
    - lw: on ready, next WB.
  - WB: reg_we=1 for exactly 1 cycle; pc <= (jal ? addr : pc+1); retire; next FETCH. jal: wb_addr=7, wb_sel=10, using pc before update.
  - HALT: absorbing until rst; halted=1, all request/strobe outputs 0.
- Control outputs (ra/rb/wb/alu_op/alu_b_sel/wb_sel/imm_ext) are registered from ir and held constant from DECODE through WB.
- PC arithmetic modulo 2^PC_W: pc+1 at all-ones wraps to 0; negative branch offsets wrap.
- Latency at zero-wait memories: R/I/jal = 4 cycles, lw = 5, sw = 4, branch/j = 3 (FETCH to retire inclusive).
- Memory stalls: ready low holds the state indefinitely; no timeout.
- ready inputs outside the matching state are ignored.
- Reset, synchronous:
  - Next cycle: state FETCH, pc=RESET_PC, ir=0, halted=0, illegal=0, retire=0, reg_we=0, dmem_req=0.
  - imem_req=1 from the first post-reset cycle.
  - Reset mid-MEM or mid-FETCH abandons the access with no register write and no retire.
  - Reset while halted clears halted and illegal.

Test Plan:
- Reset then zero-wait fetch of 0x0AD3 (R, funct=010? no: funct=101, rs=3, rt=2, rd=3) -> ra=3, rb=2, alu_op=101, reg_we pulses in cycle 4, pc 0 -> 1, retire once.
- lw 0x22CA (imm=0x0B, rt=1, rd=2) with dmem_ready delayed 3 cycles -> dmem_req=1, dmem_we=0 held 4 cycles, imm_ext=0x0B, wb_sel=01, wb_addr=2, reg_we one cycle after ready.
- beq at pc=0x010 with imm=0x3E (-2) and alu_zero=1 -> pc=0x00F, no reg_we. Same instruction with alu_zero=0 -> pc=0x011.
- jal 0x8ABC at pc=0x005 -> wb_addr=7, wb_sel=10, reg_we=1, then pc=0xABC. j at pc=0xFFF to 0x000 -> pc=0x000. pc+1 at 0xFFF -> 0x000.
- Opcode 0xF000 -> illegal=1, halted=1, imem_req=0 thereafter. rst pulse -> pc=RESET_PC, flags cleared, fetch resumes.
- rst asserted during a stalled sw in MEM -> dmem_req=0 next cycle, no retire, state FETCH at pc=RESET_PC.

Source files
------------

// File: rtl/mr_chips_control_if.sv
// Control-sequencer bundle: instruction/data memory handshakes plus datapath strobes.
// master = the sequencer, slave = memories and datapath.
interface mr_chips_control_if #(
   parameter int unsigned PC_W   = 12,
   parameter int unsigned DATA_W = 8
);
   logic              imem_req;
   logic [PC_W-1:0]   imem_addr;
   logic              imem_ready;
   logic [15:0]       imem_rdata;
   logic              dmem_req;
   logic              dmem_we;
   logic              dmem_ready;
   logic              alu_zero;
   logic [2:0]        alu_op;
   logic              alu_b_sel;
   logic [DATA_W-1:0] imm_ext;
   logic [2:0]        ra_addr;
   logic [2:0]        rb_addr;
   logic [2:0]        wb_addr;
   logic [1:0]        wb_sel;
   logic              reg_we;
   logic [PC_W-1:0]   pc;
   logic              retire;
   logic              halted;
   logic              illegal;

   modport master (
      output imem_req, imem_addr, dmem_req, dmem_we, alu_op, alu_b_sel, imm_ext,
             ra_addr, rb_addr, wb_addr, wb_sel, reg_we, pc, retire, halted, illegal,
      input  imem_ready, imem_rdata, dmem_ready, alu_zero
   );

   modport slave (
      input  imem_req, imem_addr, dmem_req, dmem_we, alu_op, alu_b_sel, imm_ext,
             ra_addr, rb_addr, wb_addr, wb_sel, reg_we, pc, retire, halted, illegal,
      output imem_ready, imem_rdata, dmem_ready, alu_zero
   );
endinterface

// File: rtl/mr_chips_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the mr_chips 16-bit core.
// Owns pc and ir; datapath controls are decoded from the held ir.
module mr_chips_control #(
   parameter int unsigned    PC_W     = 12,
   parameter int unsigned    DATA_W   = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input logic                clk,
   input logic                rst,
   mr_chips_control_if.master bus
);

   typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

   localparam logic [3:0] OpR    = 4'h0;
   localparam logic [3:0] OpAddi = 4'h1;
   localparam logic [3:0] OpLw   = 4'h2;
   localparam logic [3:0] OpSw   = 4'h3;
   localparam logic [3:0] OpBeq  = 4'h4;
   localparam logic [3:0] OpBne  = 4'h5;
   localparam logic [3:0] OpAndi = 4'h6;
   localparam logic [3:0] OpJ    = 4'h7;
   localparam logic [3:0] OpJal  = 4'h8;
   localparam logic [3:0] OpHalt = 4'h9;

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     ir_q, ir_d;
   logic            illegal_q, illegal_d;
   logic            retire;

   logic [3:0]      op;
   logic [PC_W-1:0] pc_inc, pc_br, jaddr;
   logic            taken;

   assign op     = ir_q[15:12];
   assign pc_inc = pc_q + PC_W'(1);
   // Branch offset is relative to pc+1; all pc arithmetic wraps at PC_W bits.
   assign pc_br  = pc_inc + {{(PC_W-6){ir_q[11]}}, ir_q[11:6]};
   assign jaddr  = PC_W'(ir_q[11:0]);
   assign taken  = (op == OpBeq) ? bus.alu_zero : ~bus.alu_zero;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StFetch;
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      illegal_d = illegal_q;
      retire    = 1'b0;
      unique case (state_q)
         StFetch: begin
            if (bus.imem_ready) begin
               ir_d    = bus.imem_rdata;
               state_d = StDecode;
            end
         end
         StDecode: begin
            if (op == OpHalt) begin
               state_d = StHalt;
            end else if (op > OpHalt) begin
               state_d   = StHalt;
               illegal_d = 1'b1;
            end else begin
               state_d = StExec;
            end
         end
         StExec: begin
            unique case (op)
               OpBeq, OpBne: begin
                  pc_d    = taken ? pc_br : pc_inc;
                  retire  = 1'b1;
                  state_d = StFetch;
               end
               OpJ: begin
                  pc_d    = jaddr;
                  retire  = 1'b1;
                  state_d = StFetch;
               end
               OpLw, OpSw: state_d = StMem;
               default:    state_d = StWb;
            endcase
         end
         StMem: begin
            if (bus.dmem_ready) begin
               if (op == OpSw) begin
                  pc_d    = pc_inc;
                  retire  = 1'b1;
                  state_d = StFetch;
               end else begin
                  state_d = StWb;
               end
            end
         end
         StWb: begin
            pc_d    = (op == OpJal) ? jaddr : pc_inc;
            retire  = 1'b1;
            state_d = StFetch;
         end
         StHalt:  state_d = StHalt;
         default: state_d = StFetch;
      endcase
   end

   // Field decode; ir is stable from DECODE through WB so these hold too.
   always_comb begin
      bus.ra_addr   = ir_q[5:3];
      bus.rb_addr   = ir_q[2:0];
      bus.wb_addr   = ir_q[2:0];
      bus.alu_op    = 3'b000;
      bus.alu_b_sel = 1'b0;
      bus.wb_sel    = 2'b00;
      unique case (op)
         OpR: begin
            bus.ra_addr = ir_q[8:6];
            bus.rb_addr = ir_q[5:3];
            bus.alu_op  = ir_q[11:9];
         end
         OpAddi, OpSw: bus.alu_b_sel = 1'b1;
         OpLw: begin
            bus.alu_b_sel = 1'b1;
            bus.wb_sel    = 2'b01;
         end
         OpBeq, OpBne: bus.alu_op = 3'b001;
         OpAndi: begin
            bus.alu_b_sel = 1'b1;
            bus.alu_op    = 3'b010;
         end
         OpJal: begin
            bus.wb_addr = 3'd7;
            bus.wb_sel  = 2'b10;
         end
         default: ;
      endcase
   end

   assign bus.imm_ext   = {{(DATA_W-6){ir_q[11]}}, ir_q[11:6]};
   assign bus.imem_req  = (state_q == StFetch);
   assign bus.imem_addr = pc_q;
   assign bus.dmem_req  = (state_q == StMem);
   assign bus.dmem_we   = (state_q == StMem) && (op == OpSw);
   // A reset cycle abandons the instruction, so it must not write or retire.
   assign bus.reg_we    = (state_q == StWb) & ~rst;
   assign bus.retire    = retire & ~rst;
   assign bus.pc        = pc_q;
   assign bus.halted    = (state_q == StHalt);
   assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_mr_chips_control.sv
// Directed bench for mr_chips_control: memories and ALU flag are driven by hand,
// every expectation is a hand-computed constant.
module tb_mr_chips_control;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fails  = 0;

   mr_chips_control_if #(.PC_W(12), .DATA_W(8)) bus ();

   mr_chips_control #(.PC_W(12), .DATA_W(8), .RESET_PC(12'h000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [15:0] instr);
      check("fetch_req", 32'(bus.imem_req), 32'd1);
      bus.imem_ready = 1'b1;
      bus.imem_rdata = instr;
      tick();
      bus.imem_ready = 1'b0;
      bus.imem_rdata = 16'h0000;
   endtask

   task automatic do_j(input logic [11:0] addr);
      fetch({4'h7, addr});
      tick();
      tick();
      check("j_pc", 32'(bus.pc), 32'(addr));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_pc", 32'(bus.pc), 32'h000);
      check("rst_halted", 32'(bus.halted), 32'd0);
      check("rst_illegal", 32'(bus.illegal), 32'd0);
      check("rst_imem_req", 32'(bus.imem_req), 32'd1);
      check("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
      check("rst_reg_we", 32'(bus.reg_we), 32'd0);
   endtask

   initial begin
      bus.imem_ready = 1'b0;
      bus.imem_rdata = 16'h0000;
      bus.dmem_ready = 1'b0;
      bus.alu_zero   = 1'b0;
      tick();
      do_reset();
      check("rst_retire", 32'(bus.retire), 32'd0);

      // R-type 0x0AD3: funct 101, rs 3, rt 2, rd 3
      check("r_addr", 32'(bus.imem_addr), 32'h000);
      fetch(16'h0AD3);
      check("r_ra", 32'(bus.ra_addr), 32'd3);
      check("r_rb", 32'(bus.rb_addr), 32'd2);
      check("r_aluop", 32'(bus.alu_op), 32'd5);
      check("r_we_dec", 32'(bus.reg_we), 32'd0);
      tick();
      check("r_we_exec", 32'(bus.reg_we), 32'd0);
      check("r_ret_exec", 32'(bus.retire), 32'd0);
      tick();
      check("r_we_wb", 32'(bus.reg_we), 32'd1);
      check("r_ret_wb", 32'(bus.retire), 32'd1);
      check("r_wb_addr", 32'(bus.wb_addr), 32'd3);
      check("r_bsel", 32'(bus.alu_b_sel), 32'd0);
      tick();
      check("r_pc", 32'(bus.pc), 32'h001);
      check("r_we_after", 32'(bus.reg_we), 32'd0);

      // lw 0x22CA with dmem_ready on the 4th MEM cycle
      fetch(16'h22CA);
      check("lw_imm", 32'(bus.imm_ext), 32'h0B);
      check("lw_wbsel", 32'(bus.wb_sel), 32'd1);
      check("lw_wbaddr", 32'(bus.wb_addr), 32'd2);
      check("lw_ra", 32'(bus.ra_addr), 32'd1);
      check("lw_bsel", 32'(bus.alu_b_sel), 32'd1);
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         bus.dmem_ready = (i == 3);
         #1;
         check("lw_dreq", 32'(bus.dmem_req), 32'd1);
         check("lw_dwe", 32'(bus.dmem_we), 32'd0);
         check("lw_we_mem", 32'(bus.reg_we), 32'd0);
         check("lw_ret_mem", 32'(bus.retire), 32'd0);
         tick();
      end
      bus.dmem_ready = 1'b0;
      check("lw_we_wb", 32'(bus.reg_we), 32'd1);
      check("lw_ret_wb", 32'(bus.retire), 32'd1);
      check("lw_dreq_wb", 32'(bus.dmem_req), 32'd0);
      tick();
      check("lw_pc", 32'(bus.pc), 32'h002);

      // beq imm -2 at 0x010: taken -> 0x00F, not taken -> 0x011
      do_j(12'h010);
      fetch(16'h4F80);
      check("beq_imm", 32'(bus.imm_ext), 32'hFE);
      check("beq_aluop", 32'(bus.alu_op), 32'd1);
      tick();
      bus.alu_zero = 1'b1;
      #1;
      check("beq_ret", 32'(bus.retire), 32'd1);
      check("beq_we", 32'(bus.reg_we), 32'd0);
      tick();
      bus.alu_zero = 1'b0;
      check("beq_taken_pc", 32'(bus.pc), 32'h00F);
      do_j(12'h010);
      fetch(16'h4F80);
      tick();
      tick();
      check("beq_nt_pc", 32'(bus.pc), 32'h011);
      // bne with alu_zero=0 is taken: 0x011 + 1 - 2
      fetch(16'h5F80);
      tick();
      tick();
      check("bne_taken_pc", 32'(bus.pc), 32'h010);

      // jal 0x8ABC at 0x005
      do_j(12'h005);
      fetch(16'h8ABC);
      check("jal_wbaddr", 32'(bus.wb_addr), 32'd7);
      check("jal_wbsel", 32'(bus.wb_sel), 32'd2);
      tick();
      check("jal_we_exec", 32'(bus.reg_we), 32'd0);
      tick();
      check("jal_we_wb", 32'(bus.reg_we), 32'd1);
      check("jal_pc_wb", 32'(bus.pc), 32'h005);
      tick();
      check("jal_pc", 32'(bus.pc), 32'hABC);

      // pc wrap cases
      do_j(12'hFFF);
      do_j(12'h000);
      do_j(12'hFFF);
      fetch(16'h1000);
      check("addi_bsel", 32'(bus.alu_b_sel), 32'd1);
      check("addi_wbsel", 32'(bus.wb_sel), 32'd0);
      tick();
      tick();
      tick();
      check("addi_wrap_pc", 32'(bus.pc), 32'h000);

      // zero-wait sw retires in MEM
      fetch(16'h3000);
      tick();
      tick();
      bus.dmem_ready = 1'b1;
      #1;
      check("sw_dwe", 32'(bus.dmem_we), 32'd1);
      check("sw_ret", 32'(bus.retire), 32'd1);
      check("sw_we", 32'(bus.reg_we), 32'd0);
      tick();
      bus.dmem_ready = 1'b0;
      check("sw_pc", 32'(bus.pc), 32'h001);

      // illegal opcode halts; stray ready is ignored
      fetch(16'hF000);
      tick();
      bus.imem_ready = 1'b1;
      tick();
      tick();
      bus.imem_ready = 1'b0;
      check("ill_halted", 32'(bus.halted), 32'd1);
      check("ill_flag", 32'(bus.illegal), 32'd1);
      check("ill_imem_req", 32'(bus.imem_req), 32'd0);
      check("ill_pc", 32'(bus.pc), 32'h001);
      do_reset();

      // halt opcode: halted but not illegal
      fetch(16'h9000);
      tick();
      check("halt_halted", 32'(bus.halted), 32'd1);
      check("halt_illegal", 32'(bus.illegal), 32'd0);
      do_reset();

      // reset during a stalled sw abandons it
      do_j(12'h020);
      fetch(16'h3000);
      tick();
      tick();
      check("swr_dreq", 32'(bus.dmem_req), 32'd1);
      tick();
      rst = 1'b1;
      #1;
      check("swr_ret_rst", 32'(bus.retire), 32'd0);
      tick();
      rst = 1'b0;
      check("swr_dreq_after", 32'(bus.dmem_req), 32'd0);
      check("swr_ret_after", 32'(bus.retire), 32'd0);
      check("swr_imem_req", 32'(bus.imem_req), 32'd1);
      check("swr_pc", 32'(bus.pc), 32'h000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
